// File: rtl/lampfpu_log_arb.sv
// Two-requester round-robin front end for the bfloat16 log unit; one operation in flight.
// Optional WAIT watchdog enabled by defining LAMPFPU_LOG_ARB_TIMEOUT_EN.
module lampfpu_log_arb #(
  parameter int unsigned TIMEOUT_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid_i,
  input  logic [31:0] req_op_i,
  output logic [1:0]  req_ready_o,
  output logic [1:0]  resp_valid_o,
  input  logic [1:0]  resp_ready_i,
  output logic [15:0] resp_res_o,
  output logic        resp_isToRound_o,
  output logic        resp_err_o,
  output logic        doLog_o,
  output logic [15:0] lg_op_o,
  output logic [3:0]  lg_cls_o,
  input  logic        lg_valid_i,
  input  logic [15:0] lg_res_i,
  input  logic        lg_isToRound_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state;
  logic        rr_ptr;
  logic        gnt_id;

  logic        gnt_c;
  logic [1:0]  ready_c;
  logic        xfer_c;
  logic [15:0] op_c;
  logic [7:0]  e_c;
  logic [6:0]  f_c;
  logic [3:0]  cls_c;

`ifdef LAMPFPU_LOG_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] wait_cnt;
`endif

  // Grant selection and operand classification for the candidate being granted.
  always_comb begin
    gnt_c = rr_ptr;
    if (req_valid_i == 2'b01) begin
      gnt_c = 1'b0;
    end else if (req_valid_i == 2'b10) begin
      gnt_c = 1'b1;
    end
    ready_c = 2'b00;
    if ((state == IDLE) && (req_valid_i != 2'b00)) begin
      ready_c[gnt_c] = 1'b1;
    end
    xfer_c = |(req_valid_i & ready_c);
    op_c   = gnt_c ? req_op_i[31:16] : req_op_i[15:0];
    e_c    = op_c[14:7];
    f_c    = op_c[6:0];
    // Denormals (e==0) are treated as zero.
    cls_c  = {(e_c == 8'h00),
              (e_c == 8'hFF) && (f_c == 7'h00),
              (e_c == 8'hFF) && (f_c != 7'h00) && !f_c[6],
              (e_c == 8'hFF) && f_c[6]};
  end

  assign req_ready_o = ready_c;

`ifndef LAMPFPU_LOG_ARB_TIMEOUT_EN
  assign resp_err_o = 1'b0;
`endif

  // Arbiter FSM; operand and its class flags are captured together at the transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      rr_ptr           <= 1'b0;
      gnt_id           <= 1'b0;
      lg_op_o          <= 16'h0000;
      lg_cls_o         <= 4'h0;
      doLog_o          <= 1'b0;
      resp_valid_o     <= 2'b00;
      resp_res_o       <= 16'h0000;
      resp_isToRound_o <= 1'b0;
`ifdef LAMPFPU_LOG_ARB_TIMEOUT_EN
      resp_err_o       <= 1'b0;
      wait_cnt         <= '0;
`endif
    end else begin
      doLog_o <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer_c) begin
            lg_op_o  <= op_c;
            lg_cls_o <= cls_c;
            gnt_id   <= gnt_c;
            rr_ptr   <= ~gnt_c;
            doLog_o  <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef LAMPFPU_LOG_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (lg_valid_i) begin
            resp_res_o       <= lg_res_i;
            resp_isToRound_o <= lg_isToRound_i;
            resp_valid_o     <= gnt_id ? 2'b10 : 2'b01;
`ifdef LAMPFPU_LOG_ARB_TIMEOUT_EN
            resp_err_o       <= 1'b0;
`endif
            state            <= RESP;
          end
`ifdef LAMPFPU_LOG_ARB_TIMEOUT_EN
          // A result arriving on the final allowed cycle still takes priority.
          else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            resp_res_o       <= 16'h7FC0;
            resp_isToRound_o <= 1'b0;
            resp_err_o       <= 1'b1;
            resp_valid_o     <= gnt_id ? 2'b10 : 2'b01;
            state            <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          if (resp_ready_i[gnt_id]) begin
            resp_valid_o <= 2'b00;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lampfpu_log_arb.md
LAMPFPU_LOG_ARB -- requirements
Module: lampFPU_log_arb

Interface
REQ-001 Parameter TIMEOUT_CYC, default 4: number of WAIT cycles allowed before the watchdog fires; used only when the configuration macro is defined.
REQ-002 The port list SHALL begin: clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 req_valid_i  in  2  per-requester operation request; bit i belongs to requester i.
REQ-005 req_op_i  in  32  packed bfloat16 operands {op1[15:0], op0[15:0]}, each laid out as {s, e[7:0], f[6:0]}.
REQ-006 req_ready_o  out  2  grant, at most one bit high; a transfer occurs when req_valid_i[i] & req_ready_o[i].
REQ-007 resp_valid_o  out  2  result valid for requester i, at most one bit high.
REQ-008 resp_ready_i  in  2  requester i accepts the result.
REQ-009 resp_res_o  out  16  result {s, e, f}, shared by both requesters.
REQ-010 resp_isToRound_o  out  1  isToRound flag from the log unit, passed through.
REQ-011 resp_err_o  out  1  watchdog timeout flag.
REQ-012 doLog_o  out  1  one-cycle start pulse to the log unit.
REQ-013 lg_op_o  out  16  registered operand {s, e, f} to the log unit.
REQ-014 lg_cls_o  out  4  operand class flags {isZ, isInf, isSNAN, isQNAN}.
REQ-015 lg_valid_i  in  1  log unit result valid, one cycle after doLog_o.
REQ-016 lg_res_i  in  16  log unit result {s, e, f}.
REQ-017 lg_isToRound_i  in  1  log unit isToRound flag.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP, encoded as enum logic[1:0].
REQ-019 In IDLE, req_ready_o SHALL be computed combinationally and SHALL be high only in IDLE:
- only one requester valid -> grant that requester;
- both valid -> grant requester rr_ptr.
REQ-020 On a transfer, the block SHALL register the operand and gnt_id, set rr_ptr to ~gnt_id, and go to ISSUE.
REQ-021 Classification SHALL be done on the registered operand:
- isZ = (e==0), so denormals are flushed to zero;
- isInf = (e==FF) & (f==0);
- isQNAN = (e==FF) & f[6];
- isSNAN = (e==FF) & (f!=0) & ~f[6].
REQ-022 In ISSUE, doLog_o SHALL be 1 for exactly one cycle, and the next state SHALL be WAIT.
REQ-023 lg_op_o and lg_cls_o SHALL stay stable from ISSUE until the block leaves WAIT.
REQ-024 In WAIT, when lg_valid_i=1 the block SHALL capture lg_res_i and lg_isToRound_i, clear resp_err, and go to RESP.
REQ-025 lg_valid_i SHALL be ignored in every state other than WAIT.
REQ-026 In RESP:
- resp_valid_o[gnt_id]=1, all other bits 0;
- data SHALL be held stable until resp_ready_i[gnt_id]=1;
- the next state is then IDLE;
- no new request SHALL be granted in that same cycle.
REQ-027 resp_ready_i bits not belonging to gnt_id SHALL be ignored.
REQ-028 Minimum latency from transfer to resp_valid_o SHALL be 3 cycles, giving one operation in flight at a time.
REQ-029 The fairness bound SHALL be: with both requesters valid continuously, grants alternate 0,1,0,1 and neither requester waits more than one operation.
REQ-030 A requester that drops req_valid_i before it is granted SHALL NOT be served.

Reset
REQ-031 While rst=1, every output and internal state element SHALL take its reset value on the next clock edge:
- state=IDLE, rr_ptr=0, gnt_id=0;
- operand and result registers=0;
- doLog_o=0, resp_valid_o=0, resp_err_o=0.
REQ-032 A reset asserted mid-operation SHALL discard the in-flight operation, and a later lg_valid_i SHALL be ignored because the state is IDLE.

Configuration
REQ-033 With macro LAMPFPU_LOG_ARB_TIMEOUT_EN defined, a counter SHALL:
- clear on entry to WAIT and increment each cycle in WAIT;
- when it reaches TIMEOUT_CYC with no lg_valid_i, go to RESP with resp_res_o=16'h7FC0, resp_err_o=1, resp_isToRound_o=0;
- let lg_valid_i win if it arrives in the same cycle the counter reaches TIMEOUT_CYC.
REQ-034 Without the macro, no counter SHALL be built, WAIT SHALL last indefinitely, and resp_err_o SHALL be tied to 0.

Verification
REQ-035 Single request: req_valid_i=01, op0=16'h4000 (2.0):
- cycle 0: req_ready_o=01;
- cycle 1: doLog_o=1 with lg_cls_o=0000;
- cycle 2: log unit returns 16'h3F31;
- cycle 3: resp_valid_o=01 with resp_res_o=16'h3F31.
REQ-036 Contention: both requesters valid continuously with rr_ptr=0 -> grant order 0,1,0,1, and resp_valid_o targets the matching bit each time.
REQ-037 Backpressure: hold resp_ready_i=00 for 5 cycles in RESP -> resp_valid_o and resp_res_o stay stable and req_ready_o stays 00.
REQ-038 Classification: op=16'h7F81 -> lg_cls_o=0010; op=16'hFF80 -> 0100; op=16'h0001 -> 1000.
REQ-039 Reset: rst=1 during WAIT, then lg_valid_i pulses -> all outputs are 0 and state=IDLE.
REQ-040 Timeout (macro on, TIMEOUT_CYC=4): lg_valid_i is never asserted -> after 4 WAIT cycles resp_res_o=16'h7FC0 and resp_err_o=1.
